// File: rtl/keypad_scan.sv
// -----------------------------------------------------------------------------
// keypad_scan
//
// Row-scanning reader for a 4x4 active-low matrix keypad. One row is driven
// low at a time for SCAN_DIV cycles, the synchronized column lines are sampled
// at the end of that dwell, and a 16-bit snapshot is assembled per full scan.
// Each completed snapshot is classified as NONE / SINGLE(k) / MULTI. A class
// must repeat for DEBOUNCE_SCANS consecutive scans before it is committed, and
// the committed classes drive a two-state press/release event FSM.
//
// Parameters:
//   SCAN_DIV        cycles each row is driven before its columns are sampled
//   DEBOUNCE_SCANS  identical consecutive scans needed to commit (1..15)
//
// Ports:
//   clk_i          system clock
//   arst_i         asynchronous active-high reset
//   col_i[3:0]     column lines, active-low, asynchronous to clk_i
//   row_o[3:0]     row drive, active-low, exactly one bit low
//   key_code_o     code (row*4+col) of the last committed key
//   key_valid_o    one-cycle pulse on a committed key press
//   key_release_o  one-cycle pulse when the held key is released
//   key_pressed_o  high while a committed key is held
// -----------------------------------------------------------------------------
module keypad_scan #(
    parameter int SCAN_DIV       = 50000,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic       clk_i,
    input  logic       arst_i,
    input  logic [3:0] col_i,
    output logic [3:0] row_o,
    output logic [3:0] key_code_o,
    output logic       key_valid_o,
    output logic       key_release_o,
    output logic       key_pressed_o
);

    localparam int              DW         = $clog2(SCAN_DIV);
    localparam logic [DW-1:0]   DWELL_LAST = DW'(SCAN_DIV - 1);
    localparam logic [3:0]      DEB        = 4'(DEBOUNCE_SCANS);

    typedef enum logic [1:0] {
        CLS_NONE   = 2'd0,
        CLS_SINGLE = 2'd1,
        CLS_MULTI  = 2'd2
    } cls_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HELD = 1'b1
    } state_t;

    // ------------------------------------------------------------------
    // Column synchronizer; idle (released) level is all ones.
    // ------------------------------------------------------------------
    logic [3:0] col_meta;
    logic [3:0] col_s;

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            col_meta <= 4'hF;
            col_s    <= 4'hF;
        end else begin
            col_meta <= col_i;
            col_s    <= col_meta;
        end
    end

    // ------------------------------------------------------------------
    // Row dwell counter and row index
    // ------------------------------------------------------------------
    logic [DW-1:0] dwell_reg;
    logic [1:0]    row_reg;
    logic          tc;
    logic          scan_done;

    assign tc        = (dwell_reg == DWELL_LAST);
    assign scan_done = tc && (row_reg == 2'd3);
    assign row_o     = ~(4'b0001 << row_reg);

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            dwell_reg <= '0;
            row_reg   <= 2'd0;
        end else if (tc) begin
            dwell_reg <= '0;
            row_reg   <= row_reg + 2'd1;
        end else begin
            dwell_reg <= dwell_reg + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Snapshot: one 4-bit slice per row, 1 = pressed
    // ------------------------------------------------------------------
    logic [15:0] snapshot_reg;

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            snapshot_reg <= 16'h0000;
        end else if (tc) begin
            snapshot_reg[row_reg*4 +: 4] <= ~col_s;
        end
    end

    // ------------------------------------------------------------------
    // Classification of the completed scan. The row-3 slice is taken
    // straight from col_s because it is being written on this very edge.
    // ------------------------------------------------------------------
    logic [15:0] snap_full;
    logic [1:0]  hit_cnt;
    logic [3:0]  hit_key;
    cls_t        cls_type;
    logic [3:0]  cls_key;

    always_comb begin
        snap_full        = snapshot_reg;
        snap_full[15:12] = ~col_s;
        hit_cnt          = 2'd0;
        hit_key          = 4'd0;
        for (int i = 0; i < 16; i++) begin
            if (snap_full[i]) begin
                if (hit_cnt == 2'd0) begin
                    hit_key = 4'(i);
                end
                if (hit_cnt != 2'd2) begin
                    hit_cnt = hit_cnt + 2'd1;
                end
            end
        end
        cls_type = CLS_NONE;
        cls_key  = 4'd0;
        if (hit_cnt == 2'd1) begin
            cls_type = CLS_SINGLE;
            cls_key  = hit_key;
        end else if (hit_cnt == 2'd2) begin
            cls_type = CLS_MULTI;
        end
    end

    // ------------------------------------------------------------------
    // Debounce: count consecutive identical classes, commit once on the
    // scan where the count reaches DEB.
    // ------------------------------------------------------------------
    cls_t       prev_type_reg;
    logic [3:0] prev_key_reg;
    logic [3:0] stable_cnt_reg;
    logic [3:0] stable_cnt_next;
    logic       same_cls;
    logic       commit;

    assign same_cls = (cls_type == prev_type_reg) && (cls_key == prev_key_reg);

    always_comb begin
        stable_cnt_next = stable_cnt_reg;
        if (!same_cls) begin
            stable_cnt_next = 4'd1;
        end else if (stable_cnt_reg < DEB) begin
            stable_cnt_next = stable_cnt_reg + 4'd1;
        end
    end

    // A saturated count that stays saturated must not re-commit.
    assign commit = scan_done && (stable_cnt_next == DEB) &&
                    (!same_cls || (stable_cnt_reg != DEB));

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            prev_type_reg  <= CLS_NONE;
            prev_key_reg   <= 4'd0;
            stable_cnt_reg <= 4'd0;
        end else if (scan_done) begin
            prev_type_reg  <= cls_type;
            prev_key_reg   <= cls_key;
            stable_cnt_reg <= stable_cnt_next;
        end
    end

    // ------------------------------------------------------------------
    // Event FSM with registered outputs. While HELD, any committed class
    // other than NONE is ignored so a new key reports only after release.
    // ------------------------------------------------------------------
    state_t state_reg;

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            state_reg     <= ST_IDLE;
            key_code_o    <= 4'd0;
            key_valid_o   <= 1'b0;
            key_release_o <= 1'b0;
            key_pressed_o <= 1'b0;
        end else begin
            key_valid_o   <= 1'b0;
            key_release_o <= 1'b0;
            if (commit) begin
                case (state_reg)
                    ST_IDLE: begin
                        if (cls_type == CLS_SINGLE) begin
                            key_code_o    <= cls_key;
                            key_valid_o   <= 1'b1;
                            key_pressed_o <= 1'b1;
                            state_reg     <= ST_HELD;
                        end
                    end
                    ST_HELD: begin
                        if (cls_type == CLS_NONE) begin
                            key_release_o <= 1'b1;
                            key_pressed_o <= 1'b0;
                            state_reg     <= ST_IDLE;
                        end
                    end
                    default: state_reg <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_keypad_scan.sv
// -----------------------------------------------------------------------------
// tb_keypad_scan
//
// Directed bench for keypad_scan with SCAN_DIV=4, DEBOUNCE_SCANS=2 (16-cycle
// scan). A keypad model pulls column c low only while row r is driven low for
// every pressed key (r,c). Outputs are sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_keypad_scan;

    logic        clk = 1'b0;
    logic        arst = 1'b1;
    logic [3:0]  col;
    logic [3:0]  row;
    logic [3:0]  key_code;
    logic        key_valid;
    logic        key_release;
    logic        key_pressed;

    logic [15:0] pressed = 16'h0000;

    int tests  = 0;
    int failed = 0;

    int n_valid   = 0;
    int n_release = 0;
    logic [3:0] valid_code = 4'd0;

    keypad_scan #(
        .SCAN_DIV       (4),
        .DEBOUNCE_SCANS (2)
    ) dut (
        .clk_i         (clk),
        .arst_i        (arst),
        .col_i         (col),
        .row_o         (row),
        .key_code_o    (key_code),
        .key_valid_o   (key_valid),
        .key_release_o (key_release),
        .key_pressed_o (key_pressed)
    );

    always #5 clk = ~clk;

    // Keypad matrix model
    always_comb begin
        col = 4'hF;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (pressed[r*4 + c] && (row[r] == 1'b0)) begin
                    col[c] = 1'b0;
                end
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance n cycles, counting output pulses (a 2-cycle pulse counts twice).
    task automatic run_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (key_valid === 1'b1) begin
                n_valid++;
                valid_code = key_code;
            end
            if (key_release === 1'b1) begin
                n_release++;
            end
        end
    endtask

    task automatic clear_counts();
        n_valid   = 0;
        n_release = 0;
    endtask

    initial begin
        // ---------------- reset state ----------------
        pressed = 16'h0000;
        arst    = 1'b1;
        #23;
        check("rst_row",      32'(row),         32'hE);
        check("rst_code",     32'(key_code),    32'h0);
        check("rst_valid",    32'(key_valid),   32'h0);
        check("rst_release",  32'(key_release), 32'h0);
        check("rst_pressed",  32'(key_pressed), 32'h0);

        // ---------------- row rotation, no keys ----------------
        @(negedge clk);
        arst = 1'b0;
        clear_counts();
        for (int k = 0; k <= 16; k++) begin
            logic [3:0] exp_row;
            exp_row = ~(4'b0001 << ((k / 4) % 4));
            if (k > 0) run_cycles(1);
            check($sformatf("rot_row_k%0d", k), 32'(row), 32'(exp_row));
        end
        run_cycles(32);
        check("idle_valid_cnt",   32'(n_valid),     32'd0);
        check("idle_release_cnt", 32'(n_release),   32'd0);
        check("idle_pressed",     32'(key_pressed), 32'h0);

        // ---------------- press key (2,1) -> code 9 ----------------
        clear_counts();
        pressed = 16'h0000;
        pressed[2*4 + 1] = 1'b1;
        run_cycles(48);
        check("k9_valid_cnt", 32'(n_valid),     32'd1);
        check("k9_code",      32'(valid_code),  32'd9);
        check("k9_pressed",   32'(key_pressed), 32'h1);
        clear_counts();
        run_cycles(200);
        check("k9_hold_valid_cnt", 32'(n_valid),     32'd0);
        check("k9_hold_pressed",   32'(key_pressed), 32'h1);

        // ---------------- release key 9 ----------------
        clear_counts();
        pressed = 16'h0000;
        run_cycles(48);
        check("k9_rel_cnt",     32'(n_release),   32'd1);
        check("k9_rel_pressed", 32'(key_pressed), 32'h0);
        check("k9_rel_code",    32'(key_code),    32'd9);
        check("k9_rel_valid",   32'(n_valid),     32'd0);

        // ---------------- short glitch on (0,3) ----------------
        clear_counts();
        pressed[0*4 + 3] = 1'b1;
        run_cycles(6);
        pressed = 16'h0000;
        run_cycles(48);
        check("glitch_valid_cnt", 32'(n_valid),     32'd0);
        check("glitch_pressed",   32'(key_pressed), 32'h0);

        // ---------------- multi-key handling ----------------
        clear_counts();
        pressed[1*4 + 1] = 1'b1;
        pressed[1*4 + 2] = 1'b1;
        run_cycles(48);
        check("multi_valid_cnt",   32'(n_valid),     32'd0);
        check("multi_release_cnt", 32'(n_release),   32'd0);
        check("multi_pressed",     32'(key_pressed), 32'h0);

        clear_counts();
        pressed[1*4 + 2] = 1'b0;
        run_cycles(48);
        check("k5_valid_cnt", 32'(n_valid),     32'd1);
        check("k5_code",      32'(valid_code),  32'd5);
        check("k5_pressed",   32'(key_pressed), 32'h1);

        clear_counts();
        pressed[3*4 + 0] = 1'b1;
        run_cycles(64);
        check("k5_add_valid_cnt",   32'(n_valid),     32'd0);
        check("k5_add_release_cnt", 32'(n_release),   32'd0);
        check("k5_add_pressed",     32'(key_pressed), 32'h1);
        check("k5_add_code",        32'(key_code),    32'd5);

        clear_counts();
        pressed = 16'h0000;
        run_cycles(48);
        check("k5_rel_cnt",       32'(n_release),   32'd1);
        check("k5_rel_valid_cnt", 32'(n_valid),     32'd0);
        check("k5_rel_pressed",   32'(key_pressed), 32'h0);
        check("k5_rel_code",      32'(key_code),    32'd5);

        // ---------------- reset mid-press on (3,3) ----------------
        clear_counts();
        pressed[3*4 + 3] = 1'b1;
        run_cycles(48);
        check("k15_valid_cnt", 32'(n_valid),     32'd1);
        check("k15_code",      32'(valid_code),  32'd15);
        run_cycles(7);
        #2;
        arst = 1'b1;
        #1;
        check("arst_row",     32'(row),         32'hE);
        check("arst_code",    32'(key_code),    32'h0);
        check("arst_pressed", 32'(key_pressed), 32'h0);
        check("arst_valid",   32'(key_valid),   32'h0);
        clear_counts();
        run_cycles(3);
        arst = 1'b0;
        check("arst_hold_release", 32'(n_release), 32'd0);
        check("arst_hold_row",     32'(row),       32'hE);
        clear_counts();
        run_cycles(48);
        check("k15_rep_valid_cnt",   32'(n_valid),     32'd1);
        check("k15_rep_code",        32'(valid_code),  32'd15);
        check("k15_rep_release_cnt", 32'(n_release),   32'd0);
        check("k15_rep_pressed",     32'(key_pressed), 32'h1);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

    // Hard bound in case the run stalls.
    initial begin
        #200000;
        $display("FAIL timeout observed=stalled expected=finish");
        $fatal(1, "timeout");
    end

endmodule
